// File: rtl/fb_line_arbiter.sv
// Frame-buffer line scheduler: shares one DDR command translator between a capture
// write source and an HDMI read sink, one line per command, over two ping-pong buffers.
module fb_line_arbiter #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         LINE_BEATS      = 240,
    parameter int                         LINES_PER_FRAME = 1080,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_BASE0     = 28'h0000000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_BASE1     = 28'h0200000
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_frame_start,
    input  logic                       wr_line_req,
    output logic                       wr_line_ack,
    input  logic                       rd_frame_start,
    input  logic                       rd_line_req,
    output logic                       rd_line_ack,
    output logic                       wr_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [31:0]                wr_cmd_len,
    input  logic                       wr_cmd_ready,
    input  logic                       wr_cmd_done,
    output logic                       rd_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [31:0]                rd_cmd_len,
    input  logic                       rd_cmd_ready,
    input  logic                       rd_cmd_done,
    output logic                       wr_buf,
    output logic                       rd_buf
);

    localparam logic [11:0]                L_LPF    = 12'(LINES_PER_FRAME);
    localparam logic [CTRL_ADDR_WIDTH-1:0] L_STRIDE = CTRL_ADDR_WIDTH'(LINE_BEATS * 8);
    localparam logic [31:0]                L_LEN    = 32'(LINE_BEATS);
    localparam logic                       G_WR     = 1'b0;
    localparam logic                       G_RD     = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic [11:0]                r_wr_line, r_rd_line;
    logic                       r_wr_buf, r_rd_buf, r_last_buf, r_last_grant;
    logic                       r_wr_fs_pend, r_rd_fs_pend;
    logic [CTRL_ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
    logic                       r_wr_cmd_en, r_rd_cmd_en, r_wr_ack, r_rd_ack;
    logic [31:0]                r_cmd_len;

    logic                       w_wr_busy, w_rd_busy, w_wr_apply, w_rd_apply, w_wr_swap;
    logic                       w_wr_buf_nxt, w_last_buf_nxt;
    logic [11:0]                w_wr_line_eff, w_rd_line_eff;
    logic                       w_wr_elig, w_rd_elig;
    logic                       w_wr_issue, w_rd_issue, w_wr_fin, w_rd_fin;

    function automatic logic [CTRL_ADDR_WIDTH-1:0] f_base(input logic sel);
        return sel ? FRAME_BASE1 : FRAME_BASE0;
    endfunction

    // A frame start is deferred while its own side has a command in flight.
    assign w_wr_busy      = (r_state == S_WR_ISSUE) || (r_state == S_WR_WAIT);
    assign w_rd_busy      = (r_state == S_RD_ISSUE) || (r_state == S_RD_WAIT);
    assign w_wr_apply     = !w_wr_busy && (wr_frame_start || r_wr_fs_pend);
    assign w_rd_apply     = !w_rd_busy && (rd_frame_start || r_rd_fs_pend);
    assign w_wr_swap      = w_wr_apply && (r_wr_line == L_LPF);
    assign w_wr_buf_nxt   = w_wr_swap ? ~r_wr_buf : r_wr_buf;
    assign w_last_buf_nxt = w_wr_swap ? r_wr_buf : r_last_buf;
    assign w_wr_line_eff  = w_wr_apply ? 12'd0 : r_wr_line;
    assign w_rd_line_eff  = w_rd_apply ? 12'd0 : r_rd_line;
    assign w_wr_elig      = wr_line_req && (w_wr_line_eff < L_LPF);
    assign w_rd_elig      = rd_line_req && (w_rd_line_eff < L_LPF);

    // Next-state and command/completion strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_issue  = 1'b0;
        w_rd_issue  = 1'b0;
        w_wr_fin    = 1'b0;
        w_rd_fin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_elig && w_rd_elig) begin
                    w_state_nxt = (r_last_grant == G_RD) ? S_WR_ISSUE : S_RD_ISSUE;
                end else if (w_wr_elig) begin
                    w_state_nxt = S_WR_ISSUE;
                end else if (w_rd_elig) begin
                    w_state_nxt = S_RD_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_ISSUE: begin
                if (wr_cmd_ready) begin
                    w_wr_issue  = 1'b1;
                    w_state_nxt = S_WR_WAIT;
                end else begin
                    w_state_nxt = S_WR_ISSUE;
                end
            end
            S_WR_WAIT: begin
                if (wr_cmd_done) begin
                    w_wr_fin    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WR_WAIT;
                end
            end
            S_RD_ISSUE: begin
                if (rd_cmd_ready) begin
                    w_rd_issue  = 1'b1;
                    w_state_nxt = S_RD_WAIT;
                end else begin
                    w_state_nxt = S_RD_ISSUE;
                end
            end
            S_RD_WAIT: begin
                if (rd_cmd_done) begin
                    w_rd_fin    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer selection, line counters, addresses and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_line    <= 12'd0;
            r_rd_line    <= 12'd0;
            r_wr_buf     <= 1'b0;
            r_rd_buf     <= 1'b0;
            r_last_buf   <= 1'b0;
            r_last_grant <= G_RD;
            r_wr_fs_pend <= 1'b0;
            r_rd_fs_pend <= 1'b0;
            r_wr_addr    <= FRAME_BASE0;
            r_rd_addr    <= FRAME_BASE0;
            r_wr_cmd_en  <= 1'b0;
            r_rd_cmd_en  <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_cmd_len    <= L_LEN;
        end else begin
            r_wr_cmd_en <= w_wr_issue;
            r_rd_cmd_en <= w_rd_issue;
            r_wr_ack    <= w_wr_fin;
            r_rd_ack    <= w_rd_fin;
            r_cmd_len   <= L_LEN;

            if (w_wr_busy && wr_frame_start) begin
                r_wr_fs_pend <= 1'b1;
            end else if (w_wr_apply) begin
                r_wr_fs_pend <= 1'b0;
            end
            if (w_rd_busy && rd_frame_start) begin
                r_rd_fs_pend <= 1'b1;
            end else if (w_rd_apply) begin
                r_rd_fs_pend <= 1'b0;
            end

            // An incomplete frame keeps its buffer and is rewritten from line 0.
            if (w_wr_apply) begin
                r_wr_buf   <= w_wr_buf_nxt;
                r_last_buf <= w_last_buf_nxt;
                r_wr_line  <= 12'd0;
                r_wr_addr  <= f_base(w_wr_buf_nxt);
            end else if (w_wr_fin) begin
                if (r_wr_line != L_LPF) begin
                    r_wr_line <= r_wr_line + 12'd1;
                end
                r_wr_addr <= r_wr_addr + L_STRIDE;
            end

            if (w_rd_apply) begin
                r_rd_buf  <= w_last_buf_nxt;
                r_rd_line <= 12'd0;
                r_rd_addr <= f_base(w_last_buf_nxt);
            end else if (w_rd_fin) begin
                if (r_rd_line != L_LPF) begin
                    r_rd_line <= r_rd_line + 12'd1;
                end
                r_rd_addr <= r_rd_addr + L_STRIDE;
            end

            if (w_wr_fin) begin
                r_last_grant <= G_WR;
            end else if (w_rd_fin) begin
                r_last_grant <= G_RD;
            end
        end
    end

    assign wr_cmd_en   = r_wr_cmd_en;
    assign rd_cmd_en   = r_rd_cmd_en;
    assign wr_cmd_addr = r_wr_addr;
    assign rd_cmd_addr = r_rd_addr;
    assign wr_cmd_len  = r_cmd_len;
    assign rd_cmd_len  = r_cmd_len;
    assign wr_line_ack = r_wr_ack;
    assign rd_line_ack = r_rd_ack;
    assign wr_buf      = r_wr_buf;
    assign rd_buf      = r_rd_buf;

endmodule

// File: tb/tb_fb_line_arbiter.sv
// Directed bench for fb_line_arbiter with a small frame (4 lines) and a
// latency-programmable translator responder.
module tb_fb_line_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_frame_start = 1'b0, wr_line_req = 1'b0;
    logic        rd_frame_start = 1'b0, rd_line_req = 1'b0;
    logic        wr_cmd_ready = 1'b1, wr_cmd_done = 1'b0;
    logic        rd_cmd_ready = 1'b1, rd_cmd_done = 1'b0;
    logic        wr_line_ack, rd_line_ack, wr_cmd_en, rd_cmd_en, wr_buf, rd_buf;
    logic [27:0] wr_cmd_addr, rd_cmd_addr;
    logic [31:0] wr_cmd_len, rd_cmd_len;

    int n_vec = 0;
    int n_err = 0;

    logic [27:0] wr_log[$];
    logic [27:0] rd_log[$];
    logic        order_log[$];
    int both_cnt = 0, wr_ack_cnt = 0, rd_ack_cnt = 0, wr_done_cnt = 0, rd_done_cnt = 0;
    int wr_lat = 2, rd_lat = 2, wr_timer = 0, rd_timer = 0;

    fb_line_arbiter #(
        .CTRL_ADDR_WIDTH(28),
        .LINE_BEATS     (240),
        .LINES_PER_FRAME(4),
        .FRAME_BASE0    (28'h0000000),
        .FRAME_BASE1    (28'h0200000)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .wr_frame_start (wr_frame_start),
        .wr_line_req    (wr_line_req),
        .wr_line_ack    (wr_line_ack),
        .rd_frame_start (rd_frame_start),
        .rd_line_req    (rd_line_req),
        .rd_line_ack    (rd_line_ack),
        .wr_cmd_en      (wr_cmd_en),
        .wr_cmd_addr    (wr_cmd_addr),
        .wr_cmd_len     (wr_cmd_len),
        .wr_cmd_ready   (wr_cmd_ready),
        .wr_cmd_done    (wr_cmd_done),
        .rd_cmd_en      (rd_cmd_en),
        .rd_cmd_addr    (rd_cmd_addr),
        .rd_cmd_len     (rd_cmd_len),
        .rd_cmd_ready   (rd_cmd_ready),
        .rd_cmd_done    (rd_cmd_done),
        .wr_buf         (wr_buf),
        .rd_buf         (rd_buf)
    );

    always #5 clk = ~clk;

    // Translator model: logs commands, answers with a done pulse after *_lat cycles.
    always @(negedge clk) begin
        if (!rstn) begin
            wr_timer    = 0;
            rd_timer    = 0;
            wr_cmd_done = 1'b0;
            rd_cmd_done = 1'b0;
        end else begin
            wr_cmd_done = 1'b0;
            rd_cmd_done = 1'b0;
            if (wr_cmd_en && rd_cmd_en) both_cnt++;
            if (wr_line_ack) wr_ack_cnt++;
            if (rd_line_ack) rd_ack_cnt++;
            if (wr_cmd_en) begin
                wr_log.push_back(wr_cmd_addr);
                order_log.push_back(1'b0);
                wr_timer = wr_lat;
            end else if (wr_timer > 0) begin
                wr_timer--;
                if (wr_timer == 0) begin
                    wr_cmd_done = 1'b1;
                    wr_done_cnt++;
                end
            end
            if (rd_cmd_en) begin
                rd_log.push_back(rd_cmd_addr);
                order_log.push_back(1'b1);
                rd_timer = rd_lat;
            end else if (rd_timer > 0) begin
                rd_timer--;
                if (rd_timer == 0) begin
                    rd_cmd_done = 1'b1;
                    rd_done_cnt++;
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        order_log.delete();
        both_cnt = 0; wr_ack_cnt = 0; rd_ack_cnt = 0; wr_done_cnt = 0; rd_done_cnt = 0;
    endtask

    task automatic pulse_wr_fs();
        wr_frame_start = 1'b1;
        tick(1);
        wr_frame_start = 1'b0;
        tick(1);
    endtask

    task automatic pulse_rd_fs();
        rd_frame_start = 1'b1;
        tick(1);
        rd_frame_start = 1'b0;
        tick(1);
    endtask

    task automatic write_lines(input int n);
        wr_line_req = 1'b1;
        for (int i = 0; i < 300 && wr_log.size() < n; i++) tick(1);
        wr_line_req = 1'b0;
        tick(12);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(3);
        n_vec++; if ({wr_cmd_en, rd_cmd_en, wr_line_ack, rd_line_ack} !== 4'b0000) begin
            n_err++; $display("FAIL reset_strobes: got %b expected 0000", {wr_cmd_en, rd_cmd_en, wr_line_ack, rd_line_ack}); end
        n_vec++; if ({wr_cmd_addr, rd_cmd_addr} !== {28'h0000000, 28'h0000000}) begin
            n_err++; $display("FAIL reset_addr: got wr=%h rd=%h expected 0", wr_cmd_addr, rd_cmd_addr); end
        n_vec++; if ({wr_cmd_len, rd_cmd_len} !== {32'd240, 32'd240}) begin
            n_err++; $display("FAIL reset_len: got wr=%0d rd=%0d expected 240", wr_cmd_len, rd_cmd_len); end
        n_vec++; if ({wr_buf, rd_buf} !== 2'b00) begin
            n_err++; $display("FAIL reset_buf: got %b expected 00", {wr_buf, rd_buf}); end
        rstn = 1'b1;
        tick(3);
        n_vec++; if ({wr_cmd_en, rd_cmd_en} !== 2'b00) begin
            n_err++; $display("FAIL post_reset_idle: got %b expected 00", {wr_cmd_en, rd_cmd_en}); end
    endtask

    task automatic test_round_robin();
        clear_logs();
        wr_line_req = 1'b1;
        rd_line_req = 1'b1;
        for (int i = 0; i < 300 && order_log.size() < 4; i++) tick(1);
        wr_line_req = 1'b0;
        rd_line_req = 1'b0;
        tick(12);
        n_vec++; if (order_log.size() != 4) begin
            n_err++; $display("FAIL rr_count: got %0d expected 4", order_log.size()); end
        else if ({order_log[0], order_log[1], order_log[2], order_log[3]} !== 4'b0101) begin
            n_err++; $display("FAIL rr_order: got %b expected 0101 (0=W)", {order_log[0], order_log[1], order_log[2], order_log[3]}); end
        n_vec++; if (wr_log.size() != 2 || rd_log.size() != 2) begin
            n_err++; $display("FAIL rr_logs: got wr=%0d rd=%0d expected 2/2", wr_log.size(), rd_log.size()); end
        else if ({wr_log[0], wr_log[1], rd_log[0], rd_log[1]} !== {28'h0, 28'h780, 28'h0, 28'h780}) begin
            n_err++; $display("FAIL rr_addr: got %h %h %h %h expected 0 780 0 780", wr_log[0], wr_log[1], rd_log[0], rd_log[1]); end
        n_vec++; if (both_cnt != 0) begin
            n_err++; $display("FAIL rr_exclusive: got %0d overlap cycles expected 0", both_cnt); end
        n_vec++; if (wr_ack_cnt != 2 || rd_ack_cnt != 2) begin
            n_err++; $display("FAIL rr_acks: got wr=%0d rd=%0d expected 2/2", wr_ack_cnt, rd_ack_cnt); end
    endtask

    task automatic test_seq_writes();
        clear_logs();
        pulse_wr_fs();
        n_vec++; if ({wr_buf, wr_cmd_addr} !== {1'b0, 28'h0000000}) begin
            n_err++; $display("FAIL seq_restart: got buf=%b addr=%h expected 0/0", wr_buf, wr_cmd_addr); end
        wr_cmd_ready = 1'b0;
        wr_line_req  = 1'b1;
        tick(6);
        n_vec++; if (wr_log.size() != 0) begin
            n_err++; $display("FAIL seq_ready_hold: got %0d cmds expected 0", wr_log.size()); end
        wr_cmd_ready = 1'b1;
        write_lines(3);
        n_vec++; if (wr_log.size() != 3) begin
            n_err++; $display("FAIL seq_count: got %0d expected 3", wr_log.size()); end
        else if ({wr_log[0], wr_log[1], wr_log[2]} !== {28'h0, 28'h780, 28'hF00}) begin
            n_err++; $display("FAIL seq_addr: got %h %h %h expected 0 780 f00", wr_log[0], wr_log[1], wr_log[2]); end
        n_vec++; if (wr_ack_cnt != 3 || wr_done_cnt != 3) begin
            n_err++; $display("FAIL seq_acks: got ack=%0d done=%0d expected 3/3", wr_ack_cnt, wr_done_cnt); end
        n_vec++; if (wr_cmd_addr !== 28'h0001680) begin
            n_err++; $display("FAIL seq_next_addr: got %h expected 1680", wr_cmd_addr); end
    endtask

    task automatic test_full_frame();
        clear_logs();
        pulse_wr_fs();
        wr_line_req = 1'b1;
        for (int i = 0; i < 300 && wr_log.size() < 4; i++) tick(1);
        tick(25);
        wr_line_req = 1'b0;
        n_vec++; if (wr_log.size() != 4 || wr_ack_cnt != 4) begin
            n_err++; $display("FAIL full_saturate: got cmds=%0d acks=%0d expected 4/4", wr_log.size(), wr_ack_cnt); end
        else if (wr_log[3] !== 28'h0001680) begin
            n_err++; $display("FAIL full_last_addr: got %h expected 1680", wr_log[3]); end
        pulse_wr_fs();
        n_vec++; if ({wr_buf, wr_cmd_addr} !== {1'b1, 28'h0200000}) begin
            n_err++; $display("FAIL full_swap: got buf=%b addr=%h expected 1/200000", wr_buf, wr_cmd_addr); end
        n_vec++; if (rd_cmd_addr !== 28'h0000F00) begin
            n_err++; $display("FAIL full_rd_before: got %h expected f00", rd_cmd_addr); end
        pulse_rd_fs();
        n_vec++; if ({rd_buf, rd_cmd_addr} !== {1'b0, 28'h0000000}) begin
            n_err++; $display("FAIL full_rd_start: got buf=%b addr=%h expected 0/0", rd_buf, rd_cmd_addr); end
    endtask

    task automatic test_partial_frame();
        clear_logs();
        write_lines(2);
        n_vec++; if (wr_log.size() != 2) begin
            n_err++; $display("FAIL part_count: got %0d expected 2", wr_log.size()); end
        else if ({wr_log[0], wr_log[1]} !== {28'h0200000, 28'h0200780}) begin
            n_err++; $display("FAIL part_addr: got %h %h expected 200000 200780", wr_log[0], wr_log[1]); end
        pulse_wr_fs();
        n_vec++; if ({wr_buf, wr_cmd_addr} !== {1'b1, 28'h0200000}) begin
            n_err++; $display("FAIL part_redo: got buf=%b addr=%h expected 1/200000", wr_buf, wr_cmd_addr); end
        pulse_rd_fs();
        n_vec++; if (rd_buf !== 1'b0) begin
            n_err++; $display("FAIL part_last_buf: got rd_buf=%b expected 0", rd_buf); end
        clear_logs();
        write_lines(4);
        pulse_wr_fs();
        n_vec++; if ({wr_buf, wr_cmd_addr} !== {1'b0, 28'h0000000}) begin
            n_err++; $display("FAIL part_refill_swap: got buf=%b addr=%h expected 0/0", wr_buf, wr_cmd_addr); end
    endtask

    task automatic test_rd_pending();
        clear_logs();
        rd_lat = 8;
        rd_line_req = 1'b1;
        for (int i = 0; i < 300 && rd_log.size() < 1; i++) tick(1);
        rd_line_req = 1'b0;
        tick(1);
        pulse_rd_fs();
        n_vec++; if ({rd_buf, rd_cmd_addr} !== {1'b0, 28'h0000000}) begin
            n_err++; $display("FAIL pend_held: got buf=%b addr=%h expected 0/0", rd_buf, rd_cmd_addr); end
        for (int i = 0; i < 100 && rd_ack_cnt < 1; i++) tick(1);
        tick(2);
        n_vec++; if ({rd_buf, rd_cmd_addr} !== {1'b1, 28'h0200000}) begin
            n_err++; $display("FAIL pend_applied: got buf=%b addr=%h expected 1/200000", rd_buf, rd_cmd_addr); end
        rd_lat = 2;
        rd_line_req = 1'b1;
        for (int i = 0; i < 300 && rd_log.size() < 2; i++) tick(1);
        rd_line_req = 1'b0;
        tick(12);
        n_vec++; if (rd_log.size() != 2) begin
            n_err++; $display("FAIL pend_count: got %0d expected 2", rd_log.size()); end
        else if ({rd_log[0], rd_log[1]} !== {28'h0000000, 28'h0200000}) begin
            n_err++; $display("FAIL pend_addr: got %h %h expected 0 200000", rd_log[0], rd_log[1]); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        wr_lat = 20;
        wr_line_req = 1'b1;
        for (int i = 0; i < 300 && wr_log.size() < 1; i++) tick(1);
        wr_line_req = 1'b0;
        tick(2);
        rstn = 1'b0;
        tick(1);
        n_vec++; if ({wr_cmd_en, rd_cmd_en, wr_line_ack, rd_line_ack, wr_buf, rd_buf} !== 6'b000000) begin
            n_err++; $display("FAIL midrst_flags: got %b expected 000000",
                              {wr_cmd_en, rd_cmd_en, wr_line_ack, rd_line_ack, wr_buf, rd_buf}); end
        n_vec++; if ({wr_cmd_addr, rd_cmd_addr, wr_cmd_len} !== {28'h0, 28'h0, 32'd240}) begin
            n_err++; $display("FAIL midrst_addr: got wr=%h rd=%h len=%0d expected 0/0/240", wr_cmd_addr, rd_cmd_addr, wr_cmd_len); end
        rstn = 1'b1;
        wr_lat = 2;
        tick(30);
        n_vec++; if (wr_ack_cnt != 0 || wr_log.size() != 1) begin
            n_err++; $display("FAIL midrst_quiet: got acks=%0d cmds=%0d expected 0/1", wr_ack_cnt, wr_log.size()); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_seq_writes();
        test_full_frame();
        test_partial_frame();
        test_rd_pending();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
